esp_spi_slave_mx: RTL and testbench
===================================

Name: esp_spi_slave_mx

Overview:
- Parametrised successor of the ESP host SPI slave.
- Runs entirely in the adc_clk domain: oversamples the host SPI pins, shifts in CMD_W-bit commands on lane 0 and decodes them.
- On the read opcode, streams memory bytes out over DATA_LANES lanes with address prefetch.
- Pushes all other commands into an internal command FIFO for the acquisition core.

Parameters:
- DATA_LANES, 4, readout lanes: 1, 2 or 4.
- CMD_W, 32, command length in bits. Opcode is cmd[CMD_W-1 -: 8]; address is cmd[ADDR_W-1:0].
- ADDR_W, 14, memory address width.
- RD_OPCODE, 8'h8F, opcode that starts a memory readout.
- FIFO_DEPTH, 4, command FIFO depth; power of 2, ≥2.

Ports:
- adc_clk  in  1  system clock; must be ≥8× the SPI clock frequency.
- rst_n  in  1  reset, synchronous and active-low.
- i_spi_clk  in  1  host SPI clock (CPOL=0), asynchronous.
- i_spi_cs_n  in  1  host chip select, asynchronous.
- i_spi_data  in  DATA_LANES  host data pins, input path; lane 0 carries commands.
- o_spi_data  out  DATA_LANES  readout slice.
- o_spi_oe  out  1  pad output enable.
- o_mem_addr  out  ADDR_W  memory read address.
- o_mem_rd  out  1  read strobe; data returns on i_mem_data one cycle later.
- i_mem_data  in  8  memory read data.
- o_cmd  out  CMD_W  FIFO head command.
- o_cmd_vld  out  1  FIFO not empty.
- i_cmd_rdy  in  1  pop; a pop occurs when o_cmd_vld & i_cmd_rdy.
- o_cmd_ovf  out  1  sticky: a command was dropped because the FIFO was full.
- i_ovf_clr  in  1  clears o_cmd_ovf.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty.
- Synchronisers: 2-FF sync on i_spi_clk, i_spi_cs_n and i_spi_data.
  - A third spi_clk stage gives rise and fall pulses.
  - Data is sampled on the rise pulse; output slices change on the fall pulse.
- States:
  - IDLE: waits for synced cs_n low, then clears bit_cnt and the shift register and enters CMD.
  - CMD: on each rise, shifts in lane 0, MSB first. On bit CMD_W:
    - opcode == RD_OPCODE: mem_addr <= cmd address, o_mem_rd=1 for one cycle, go to LOAD.
    - otherwise: push the command to the FIFO and go to DISCARD.
  - LOAD: one cycle after o_mem_rd, capture i_mem_data into out_sr, then:
    - mem_addr <= mem_addr+1, wrapping from 2^ADDR_W-1 to 0;
    - pulse o_mem_rd to prefetch the next byte into pf_byte;
    - set o_spi_oe=1 and go to STREAM.
  - STREAM:
    - On each fall, present the next slice of out_sr, MSB-first; 8/DATA_LANES slices per byte.
    - The first slice is driven on the first fall after the command.
    - After the last slice of a byte, load pf_byte into out_sr, increment mem_addr and issue the prefetch o_mem_rd.
  - DISCARD: ignores clocks until cs_n high.
- Deselect: synced cs_n high in any state returns to IDLE in that same cycle and drops o_spi_oe. A partially shifted command is discarded.
  - If cs_n rise and a spi_clk rise are synced in the same cycle, the cs_n rise wins.
- Command FIFO:
  - Push when full: the command is dropped and o_cmd_ovf <= 1.
  - Push and pop in the same cycle while full: pop first, so the push succeeds.
  - If i_ovf_clr and a new overflow occur in the same cycle, o_cmd_ovf stays 1.
- Output path: o_spi_data is registered, and is 0 whenever o_spi_oe=0.
- Latency: at most 4 adc_clk cycles from pin edge to response.
- Reset mid-transfer: the block returns to IDLE, the FIFO empties and the host must reselect.

Optional Feature:
- ESP_SPI_STAT_EN defined:
  - Opcode 8'h80 streams a status byte, {o_cmd_ovf, fifo_count[2:0] saturated, state[3:0]}, repeated for as long as cs_n is low.
  - The status read has no memory access and is not pushed to the FIFO.
- ESP_SPI_STAT_EN undefined: 8'h80 is an ordinary command and goes to the FIFO.

Decomposition:
- Package esp_spi_pkg holds:
  - the state enum (IDLE, CMD, LOAD, STREAM, DISCARD);
  - the STAT_OPCODE constant 8'h80;
  - the OPC_W=8 constant.
- One sub-module: esp_cmd_sfifo, a single-clock FIFO with parameters WIDTH and DEPTH, full/empty/count outputs and pop-before-push when full.

Test Plan:
- Write command: CMD 32'h0102_0304 on lane 0 at adc_clk/10 → o_cmd_vld=1, o_cmd=32'h01020304, o_spi_oe stays 0.
- Quad read: DATA_LANES=4, CMD 32'h8F00_0010, memory[16..18]=A5,3C,F0 → pins show 0xA,0x5,0x3,0xC,0xF,0x0; o_mem_addr sequence 0x10,0x11,0x12,0x13.
- Address wrap: ADDR_W=14, read starting at 0x3FFF over 2 bytes → second byte comes from address 0x0000.
- Overflow: i_cmd_rdy=0, FIFO_DEPTH=4, send 5 commands → 4 are held, o_cmd_ovf=1. Pop and push in the same cycle with i_ovf_clr → o_cmd_ovf clears and the count stays 4.
- Abort: raise cs_n after 17 command bits, then send 32'h0200_0001 → only 0x02000001 reaches the FIFO; o_spi_oe=0 throughout.
- Lane variants: DATA_LANES=1 and DATA_LANES=2 reading 0xA5 → bit sequence 1,0,1,0,0,1,0,1 on one lane; slice sequence 2,2,1,1 on two lanes.

Source files
------------

// File: rtl/esp_spi_pkg.sv
// Shared types and constants for the ESP SPI slave.
// Holds the FSM state enum, opcode width and status opcode.
package esp_spi_pkg;

  localparam int OPC_W = 8;
  localparam logic [OPC_W-1:0] STAT_OPCODE = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_LOAD    = 4'd2,
    ST_STREAM  = 4'd3,
    ST_DISCARD = 4'd4
  } state_e;

  function automatic logic [2:0] sat3(input int unsigned v);
    return (v > 7) ? 3'd7 : 3'(v);
  endfunction

endpackage

// File: rtl/esp_cmd_sfifo.sv
// Single-clock command FIFO; a pop frees room for a push in the same cycle.
// Ports: clk/rst_n, i_push/i_din, i_pop, o_dout, o_full, o_empty, o_count.
module esp_cmd_sfifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             pop_ok, push_ok;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == FULL_CNT);
  assign o_count = cnt_q;
  assign o_dout  = o_empty ? '0 : mem_q[rd_q];

  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= i_din;
  end

endmodule

// File: rtl/esp_spi_slave_mx.sv
// Oversampled SPI slave: lane-0 commands, multi-lane memory readout,
// other commands queued in a FIFO. Ports: SPI pins (i_spi_*, o_spi_*),
// memory read port (o_mem_*, i_mem_data), command FIFO (o_cmd*, i_cmd_rdy,
// i_ovf_clr). Optional status read via macro ESP_SPI_STAT_EN.
module esp_spi_slave_mx
  import esp_spi_pkg::*;
#(
  parameter int          DATA_LANES = 4,
  parameter int          CMD_W      = 32,
  parameter int          ADDR_W     = 14,
  parameter logic [7:0]  RD_OPCODE  = 8'h8F,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  adc_clk,
  input  logic                  rst_n,
  input  logic                  i_spi_clk,
  input  logic                  i_spi_cs_n,
  input  logic [DATA_LANES-1:0] i_spi_data,
  output logic [DATA_LANES-1:0] o_spi_data,
  output logic                  o_spi_oe,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [7:0]            i_mem_data,
  output logic [CMD_W-1:0]      o_cmd,
  output logic                  o_cmd_vld,
  input  logic                  i_cmd_rdy,
  output logic                  o_cmd_ovf,
  input  logic                  i_ovf_clr
);

  localparam int BC_W = $clog2(CMD_W + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST_SLC = 3'(8 / DATA_LANES - 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(CMD_W - 1);

  logic [2:0]            sclk_q, sclk_d;
  logic [1:0]            cs_q, cs_d;
  logic [DATA_LANES-1:0] din1_q, din2_q;
  logic                  sclk_rise, sclk_fall, cs_s;
  logic                  unused_din;

  state_e                state_q, state_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CMD_W-2:0]      sr_q, sr_d;
  logic [7:0]            out_sr_q, out_sr_d;
  logic [7:0]            pf_q, pf_d;
  logic [2:0]            slc_q, slc_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  rdv_q;
  logic                  oe_q, oe_d;
  logic [DATA_LANES-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;

  logic [CMD_W-1:0]      cmd_nx;
  logic [OPC_W-1:0]      opc;
  logic                  cmd_push, cmd_pop;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;

`ifdef ESP_SPI_STAT_EN
  logic                  stat_q, stat_d;
  logic [7:0]            stat_byte;
  assign stat_byte = {ovf_q, sat3(32'(fifo_cnt)), state_q};
`else
  logic                  unused_cnt;
  assign unused_cnt = ^fifo_cnt;
`endif

  // sclk_q[0..2]: two sync stages plus an edge-detect stage.
  assign sclk_d    = {sclk_q[1:0], i_spi_clk};
  assign cs_d      = {cs_q[0], i_spi_cs_n};
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_s      = cs_q[1];
  assign unused_din = ^din2_q;

  assign cmd_pop    = ~fifo_empty & i_cmd_rdy;
  assign o_cmd_vld  = ~fifo_empty;
  assign o_cmd_ovf  = ovf_q;
  assign o_spi_oe   = oe_q;
  assign o_spi_data = data_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_rd   = mem_rd_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    out_sr_d   = out_sr_q;
    pf_d       = pf_q;
    slc_d      = slc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    oe_d       = oe_q;
    data_d     = data_q;
    cmd_push   = 1'b0;
`ifdef ESP_SPI_STAT_EN
    stat_d     = stat_q;
`endif
    cmd_nx = {sr_q, din2_q[0]};
    opc    = cmd_nx[CMD_W-1 -: OPC_W];

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        sr_d      = '0;
        state_d   = ST_CMD;
      end
      ST_CMD: begin
        if (sclk_rise) begin
          sr_d      = cmd_nx[CMD_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            if (opc == RD_OPCODE) begin
              mem_addr_d = cmd_nx[ADDR_W-1:0];
              mem_rd_d   = 1'b1;
              state_d    = ST_LOAD;
            end
`ifdef ESP_SPI_STAT_EN
            else if (opc == STAT_OPCODE) begin
              out_sr_d = stat_byte;
              slc_d    = '0;
              oe_d     = 1'b1;
              stat_d   = 1'b1;
              state_d  = ST_STREAM;
            end
`endif
            else begin
              cmd_push = 1'b1;
              state_d  = ST_DISCARD;
            end
          end
        end
      end
      ST_LOAD: begin
        // rdv_q marks the cycle the first byte is on i_mem_data.
        if (rdv_q) begin
          out_sr_d   = i_mem_data;
          mem_addr_d = mem_addr_q + 1'b1;
          mem_rd_d   = 1'b1;
          slc_d      = '0;
          oe_d       = 1'b1;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rdv_q) pf_d = i_mem_data;
        if (sclk_fall) begin
          data_d   = out_sr_q[7 -: DATA_LANES];
          out_sr_d = out_sr_q << DATA_LANES;
          slc_d    = slc_q + 1'b1;
          if (slc_q == LAST_SLC) begin
            slc_d      = '0;
            out_sr_d   = pf_q;
            mem_addr_d = mem_addr_q + 1'b1;
            mem_rd_d   = 1'b1;
`ifdef ESP_SPI_STAT_EN
            if (stat_q) begin
              out_sr_d   = stat_byte;
              mem_addr_d = mem_addr_q;
              mem_rd_d   = 1'b0;
            end
`endif
          end
        end
      end
      default: state_d = state_q;
    endcase

    // Deselect beats any same-cycle clock edge.
    if (cs_s) begin
      state_d    = ST_IDLE;
      oe_d       = 1'b0;
      data_d     = '0;
      cmd_push   = 1'b0;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
`ifdef ESP_SPI_STAT_EN
      stat_d     = 1'b0;
`endif
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (i_ovf_clr) ovf_d = 1'b0;
    if (cmd_push & fifo_full & ~cmd_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      sclk_q     <= '0;
      cs_q       <= 2'b11;
      din1_q     <= '0;
      din2_q     <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      out_sr_q   <= '0;
      pf_q       <= '0;
      slc_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rdv_q      <= 1'b0;
      oe_q       <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
`ifdef ESP_SPI_STAT_EN
      stat_q     <= 1'b0;
`endif
    end else begin
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      din1_q     <= i_spi_data;
      din2_q     <= din1_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      out_sr_q   <= out_sr_d;
      pf_q       <= pf_d;
      slc_q      <= slc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      rdv_q      <= mem_rd_q;
      oe_q       <= oe_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
`ifdef ESP_SPI_STAT_EN
      stat_q     <= stat_d;
`endif
    end
  end

  esp_cmd_sfifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (adc_clk),
    .rst_n   (rst_n),
    .i_push  (cmd_push),
    .i_din   (cmd_nx),
    .i_pop   (cmd_pop),
    .o_dout  (o_cmd),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_cnt)
  );

endmodule

// File: tb/tb_esp_spi_slave_mx.sv
// Directed bench for esp_spi_slave_mx: 4-lane DUT plus 1- and 2-lane
// instances sharing the SPI pins; scoreboard queues hold expectations.
module tb_esp_spi_slave_mx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk;
  logic        cs_n;
  logic [3:0]  sdat;
  logic        rdy;
  logic        clr;

  logic [3:0]  d4_data;
  logic        d4_oe;
  logic [13:0] d4_addr;
  logic        d4_rd;
  logic [7:0]  d4_mdat = 8'h00;
  logic [31:0] d4_cmd;
  logic        d4_vld;
  logic        d4_ovf;

  logic [0:0]  l1_data;
  logic [13:0] l1_addr;
  logic        l1_rd;
  logic [7:0]  l1_mdat = 8'h00;
  logic [1:0]  l2_data;
  logic [13:0] l2_addr;
  logic        l2_rd;
  logic [7:0]  l2_mdat = 8'h00;

  logic        unused_l1_oe, unused_l1_vld, unused_l1_ovf;
  logic [31:0] unused_l1_cmd;
  logic        unused_l2_oe, unused_l2_vld, unused_l2_ovf;
  logic [31:0] unused_l2_cmd;

  logic [7:0]  mem [0:16383];
  logic [13:0] addr_q [$];
  logic [31:0] exp_cmd [$];
  logic [3:0]  exp4 [$];
  logic [3:0]  exp2 [$];
  logic [3:0]  exp1 [$];

  logic        oe_mon = 1'b0;
  logic        oe_seen = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  esp_spi_slave_mx u_dut (
    .adc_clk    (clk),
    .rst_n      (rst_n),
    .i_spi_clk  (spi_clk),
    .i_spi_cs_n (cs_n),
    .i_spi_data (sdat),
    .o_spi_data (d4_data),
    .o_spi_oe   (d4_oe),
    .o_mem_addr (d4_addr),
    .o_mem_rd   (d4_rd),
    .i_mem_data (d4_mdat),
    .o_cmd      (d4_cmd),
    .o_cmd_vld  (d4_vld),
    .i_cmd_rdy  (rdy),
    .o_cmd_ovf  (d4_ovf),
    .i_ovf_clr  (clr)
  );

  esp_spi_slave_mx #(.DATA_LANES(1)) u_l1 (
    .adc_clk    (clk),
    .rst_n      (rst_n),
    .i_spi_clk  (spi_clk),
    .i_spi_cs_n (cs_n),
    .i_spi_data (sdat[0:0]),
    .o_spi_data (l1_data),
    .o_spi_oe   (unused_l1_oe),
    .o_mem_addr (l1_addr),
    .o_mem_rd   (l1_rd),
    .i_mem_data (l1_mdat),
    .o_cmd      (unused_l1_cmd),
    .o_cmd_vld  (unused_l1_vld),
    .i_cmd_rdy  (rdy),
    .o_cmd_ovf  (unused_l1_ovf),
    .i_ovf_clr  (clr)
  );

  esp_spi_slave_mx #(.DATA_LANES(2)) u_l2 (
    .adc_clk    (clk),
    .rst_n      (rst_n),
    .i_spi_clk  (spi_clk),
    .i_spi_cs_n (cs_n),
    .i_spi_data (sdat[1:0]),
    .o_spi_data (l2_data),
    .o_spi_oe   (unused_l2_oe),
    .o_mem_addr (l2_addr),
    .o_mem_rd   (l2_rd),
    .i_mem_data (l2_mdat),
    .o_cmd      (unused_l2_cmd),
    .o_cmd_vld  (unused_l2_vld),
    .i_cmd_rdy  (rdy),
    .o_cmd_ovf  (unused_l2_ovf),
    .i_ovf_clr  (clr)
  );

  // Synchronous-read memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (d4_rd) d4_mdat <= mem[d4_addr];
    if (l1_rd) l1_mdat <= mem[l1_addr];
    if (l2_rd) l2_mdat <= mem[l2_addr];
    if (d4_rd) addr_q.push_back(d4_addr);
  end

  always @(negedge clk)
    oe_seen <= oe_mon ? (oe_seen | d4_oe) : 1'b0;

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI bit on lane 0; optional pop/clear aligned with the push cycle.
  task automatic spi_bit(input logic b, input logic hr, input logic hc);
    sdat[0] = b;
    repeat (5) @(negedge clk);
    spi_clk = 1'b1;
    if (hr | hc) begin
      repeat (2) @(negedge clk);
      if (hr) chk("pop_head", d4_cmd, exp_cmd.pop_front());
      rdy = hr;
      clr = hc;
      @(negedge clk);
      rdy = 1'b0;
      clr = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    spi_clk = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] c, input logic hr,
                          input logic hc);
    cs_n = 1'b0;
    for (int i = 31; i >= 0; i--)
      spi_bit(c[i], (i == 0) ? hr : 1'b0, (i == 0) ? hc : 1'b0);
  endtask

  task automatic deselect();
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic drain();
    while (exp_cmd.size() > 0) begin
      @(negedge clk);
      chk("cmd_vld", d4_vld, 1);
      chk("cmd_val", d4_cmd, exp_cmd.pop_front());
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
    end
    @(negedge clk);
    chk("fifo_empty", d4_vld, 0);
  endtask

  task automatic do_read(input logic [13:0] a, input int n);
    send_cmd({8'h8F, 10'h000, a}, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      repeat (5) @(negedge clk);
      if (k == 0) chk("rd_oe", d4_oe, 1);
      if (exp4.size() > 0) chk("slice_x4", d4_data, exp4.pop_front());
      if (exp2.size() > 0) chk("slice_x2", l2_data, exp2.pop_front());
      if (exp1.size() > 0) chk("slice_x1", l1_data, exp1.pop_front());
      spi_clk = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk = 1'b0;
    end
    deselect();
    chk("oe_drop", d4_oe, 0);
  endtask

  initial begin
    rst_n = 1'b0; spi_clk = 1'b0; cs_n = 1'b1;
    sdat = 4'h0; rdy = 1'b0; clr = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_oe", d4_oe, 0);
    chk("rst_data", d4_data, 0);
    chk("rst_addr", d4_addr, 0);
    chk("rst_rd", d4_rd, 0);
    chk("rst_cmd", d4_cmd, 0);
    chk("rst_vld", d4_vld, 0);
    chk("rst_ovf", d4_ovf, 0);

    // Plain commands, including 0x80 which is ordinary here.
    oe_mon = 1'b1;
    exp_cmd.push_back(32'h0102_0304);
    send_cmd(32'h0102_0304, 1'b0, 1'b0);
    deselect();
    exp_cmd.push_back(32'h8000_0005);
    send_cmd(32'h8000_0005, 1'b0, 1'b0);
    deselect();
    chk("write_no_oe", oe_seen, 0);
    oe_mon = 1'b0;
    drain();

    // Quad read.
    mem[16] = 8'hA5; mem[17] = 8'h3C; mem[18] = 8'hF0;
    addr_q.delete();
    foreach (exp4[i]) exp4.delete(i);
    exp4.push_back(4'hA); exp4.push_back(4'h5);
    exp4.push_back(4'h3); exp4.push_back(4'hC);
    exp4.push_back(4'hF); exp4.push_back(4'h0);
    do_read(14'h0010, 6);
    chk("addr_cnt_ge4", 32'(addr_q.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      chk("addr_seq", (addr_q.size() > 0) ? addr_q.pop_front() : 14'h3FFF,
          32'h10 + i);

    // Address wrap.
    mem[16383] = 8'h5A; mem[0] = 8'hC3;
    addr_q.delete();
    exp4.push_back(4'h5); exp4.push_back(4'hA);
    exp4.push_back(4'hC); exp4.push_back(4'h3);
    do_read(14'h3FFF, 4);
    chk("wrap_a0", (addr_q.size() > 0) ? addr_q.pop_front() : 14'h1,
        32'h3FFF);
    chk("wrap_a1", (addr_q.size() > 0) ? addr_q.pop_front() : 14'h1, 0);

    // Lane variants on byte 0xA5.
    mem[32] = 8'hA5;
    exp4.push_back(4'hA); exp4.push_back(4'h5);
    exp2.push_back(4'd2); exp2.push_back(4'd2);
    exp2.push_back(4'd1); exp2.push_back(4'd1);
    exp1.push_back(1); exp1.push_back(0); exp1.push_back(1);
    exp1.push_back(0); exp1.push_back(0); exp1.push_back(1);
    exp1.push_back(0); exp1.push_back(1);
    do_read(14'h0020, 8);

    // Deselect coinciding with the final clock rise drops the command.
    cs_n = 1'b0;
    for (int i = 31; i >= 1; i--) spi_bit(1'b1, 1'b0, 1'b0);
    sdat[0] = 1'b1;
    repeat (5) @(negedge clk);
    spi_clk = 1'b1;
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    spi_clk = 1'b0;
    repeat (6) @(negedge clk);
    chk("cs_wins", d4_vld, 0);

    // Abort after 17 bits of a read, then a full command.
    oe_mon = 1'b1;
    cs_n = 1'b0;
    for (int i = 31; i >= 15; i--) begin
      logic [31:0] ab;
      ab = 32'h8F00_0010;
      spi_bit(ab[i], 1'b0, 1'b0);
    end
    deselect();
    exp_cmd.push_back(32'h0200_0001);
    send_cmd(32'h0200_0001, 1'b0, 1'b0);
    deselect();
    chk("abort_no_oe", oe_seen, 0);
    oe_mon = 1'b0;
    drain();

    // Overflow, then pop+push+clear, then clear racing a new drop.
    for (int i = 1; i <= 4; i++) begin
      exp_cmd.push_back(32'h1100_0000 * i + i);
      send_cmd(32'h1100_0000 * i + i, 1'b0, 1'b0);
      deselect();
    end
    chk("ovf_before", d4_ovf, 0);
    send_cmd(32'h5500_0005, 1'b0, 1'b0);
    deselect();
    chk("ovf_set", d4_ovf, 1);
    exp_cmd.push_back(32'h6600_0006);
    send_cmd(32'h6600_0006, 1'b1, 1'b1);
    deselect();
    chk("ovf_popclr", d4_ovf, 0);
    send_cmd(32'h7700_0007, 1'b0, 1'b1);
    deselect();
    chk("ovf_clr_vs_new", d4_ovf, 1);
    drain();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("ovf_cleared", d4_ovf, 0);

    // Reset in the middle of a readout with a queued command.
    send_cmd(32'h0404_0404, 1'b0, 1'b0);
    deselect();
    exp4.push_back(4'hA);
    send_cmd(32'h8F00_0010, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_slice", d4_data, exp4.pop_front());
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_oe", d4_oe, 0);
    chk("mrst_data", d4_data, 0);
    chk("mrst_vld", d4_vld, 0);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    exp_cmd.push_back(32'h0505_0505);
    send_cmd(32'h0505_0505, 1'b0, 1'b0);
    deselect();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
